alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters (0: core execute path, 1: auxiliary/debug path).
//  Each requester issues operand/opcode transactions over valid/ready; results return over valid/ready.
//  Round-robin arbitration, one transaction in flight, operands and results registered.
//  Sits between the requesters and the ALU; the ALU's 4-bit opcode encoding passes through unchanged.
// PARAMETERS
//  XLEN  32  operand/result width
//  OPW   4   ALU opcode width
//  CNTW  16  width of the completed-transaction counter
// PORTS
//  clk_in           in   1      clock, all state on rising edge
//  rst_n_in         in   1      reset, asynchronous, active-low
//  req_valid_in     in   2      per-requester request valid (bit i = requester i)
//  req_ready_out    out  2      per-requester request accepted this cycle
//  req0_op_1_in     in   XLEN   requester 0 operand 1
//  req0_op_2_in     in   XLEN   requester 0 operand 2
//  req0_opcode_in   in   OPW    requester 0 ALU opcode
//  req1_op_1_in     in   XLEN   requester 1 operand 1
//  req1_op_2_in     in   XLEN   requester 1 operand 2
//  req1_opcode_in   in   OPW    requester 1 ALU opcode
//  rsp_valid_out    out  2      per-requester result valid
//  rsp_ready_in     in   2      per-requester result consumed
//  rsp_result_out   out  XLEN   result, shared bus, qualified by rsp_valid_out
//  alu_op_1_out     out  XLEN   to ALU operand 1
//  alu_op_2_out     out  XLEN   to ALU operand 2
//  alu_opcode_out   out  OPW    to ALU opcode
//  alu_result_in    in   XLEN   from ALU result (combinational)
//  busy_out         out  1      high in every state except IDLE
//  done_count_out   out  CNTW   completed transactions, wraps at 2^CNTW
// BEHAVIOUR
//  Reset (rst_n_in low, any time): state=IDLE, operand/opcode/result regs=0, grant=0, last_grant=1,
//   done_count=0; all outputs 0. An in-flight transaction is dropped with no response.
//  FSM states IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: if any req_valid_in, grant = round-robin winner; req_ready_out[grant]=1 combinationally,
//   the other bit is 0. Latch the winner's op_1/op_2/opcode and grant, then go to EXEC.
//   req_ready_out is 0 in all non-IDLE states.
//  Round-robin: if both requesters are valid, the one not equal to last_grant wins; with one valid, it wins.
//   After reset, requester 0 wins the first contention.
//  EXEC: alu_*_out driven from latched regs (they hold latched values in all states).
//   Capture alu_result_in into the result reg, then go to RESP.
//  RESP: rsp_valid_out[grant]=1, rsp_result_out=result reg, held stable until rsp_ready_in[grant]=1.
//   On that cycle: last_grant<=grant, done_count++ (mod 2^CNTW), go to IDLE.
//   rsp_ready_in of the non-granted requester is ignored.
//  Latency: accept in cycle T -> rsp_valid at T+2. With rsp_ready held high, at most one transaction per 3 cycles.
//  rsp_result_out = 0 whenever no rsp_valid_out bit is set.
//  Opcodes are not checked. An undefined opcode yields whatever the ALU returns (0) and completes normally.
//  A requester may drop req_valid_in before acceptance without side effects. After acceptance its inputs may change freely.
// TESTING
//  Reset: rst_n_in=0 mid-EXEC -> next cycle all outputs 0, busy_out=0, no rsp_valid; count=0.
//  Single req0: op1=5, op2=7, opcode=0000 at T -> req_ready=01 at T, rsp_valid=01 and result=12 at T+2, count=1.
//  Contention: both valid from reset (r0 sub 10-3, r1 xor F0^0F) -> r0 granted first, result 7;
//   then r1, result 0xFF; then r0 again if still valid.
//  Backpressure: rsp_ready_in[1]=0 for 5 cycles during RESP -> rsp_valid/result stable;
//   req_ready stays 00 while req0 is valid.
//  Wrong-ready: in RESP for r0, rsp_ready_in=10 -> no completion; count unchanged; then 01 completes.
//  Wrap: preload via 2^CNTW-1 completions (CNTW=4: 15) -> one more completion gives done_count_out=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready requesters, round-robin, one transaction in flight
// Ports:
//   clk_in, rst_n_in                  clock, async active-low reset
//   req_valid_in/req_ready_out [1:0]  per-requester request handshake
//   req{0,1}_op_1/op_2/opcode_in      per-requester operands and opcode
//   rsp_valid_out/rsp_ready_in [1:0]  per-requester response handshake
//   rsp_result_out                    shared result bus, zero unless a response is valid
//   alu_op_1/op_2/opcode_out          latched operands to the ALU
//   alu_result_in                     combinational ALU result
//   busy_out                          high whenever a transaction is in flight
//   done_count_out                    completed transactions, wrapping
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [1:0]      req_valid_in,
  output logic [1:0]      req_ready_out,
  input  logic [XLEN-1:0] req0_op_1_in,
  input  logic [XLEN-1:0] req0_op_2_in,
  input  logic [OPW-1:0]  req0_opcode_in,
  input  logic [XLEN-1:0] req1_op_1_in,
  input  logic [XLEN-1:0] req1_op_2_in,
  input  logic [OPW-1:0]  req1_opcode_in,
  output logic [1:0]      rsp_valid_out,
  input  logic [1:0]      rsp_ready_in,
  output logic [XLEN-1:0] rsp_result_out,
  output logic [XLEN-1:0] alu_op_1_out,
  output logic [XLEN-1:0] alu_op_2_out,
  output logic [OPW-1:0]  alu_opcode_out,
  input  logic [XLEN-1:0] alu_result_in,
  output logic            busy_out,
  output logic [CNTW-1:0] done_count_out
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic grant, last_grant, win, accept, complete;
  logic [XLEN-1:0] op_1, op_2, result;
  logic [OPW-1:0] opcode;
  logic [CNTW-1:0] done_count;
  always_comb begin
    // both valid: the one not served last wins; otherwise the single valid one
    win = (&req_valid_in) ? ~last_grant : req_valid_in[1];
    accept = (state == IDLE) && (|req_valid_in);
    complete = (state == RESP) && rsp_ready_in[grant];
    state_nx = accept ? EXEC : (state == EXEC) ? RESP : complete ? IDLE : state;
    // gated by reset so the handshake is quiet while reset is held
    req_ready_out = (accept && rst_n_in) ? (win ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid_out = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    rsp_result_out = (state == RESP) ? result : '0;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      op_1 <= '0;
      op_2 <= '0;
      opcode <= '0;
      result <= '0;
      done_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        grant <= win;
        op_1 <= win ? req1_op_1_in : req0_op_1_in;
        op_2 <= win ? req1_op_2_in : req0_op_2_in;
        opcode <= win ? req1_opcode_in : req0_opcode_in;
      end
      if (state == EXEC) result <= alu_result_in;
      if (complete) begin
        last_grant <= grant;
        done_count <= done_count + 1'b1;
      end
    end
  end
  assign alu_op_1_out = op_1;
  assign alu_op_2_out = op_2;
  assign alu_opcode_out = opcode;
  assign busy_out = (state != IDLE);
  assign done_count_out = done_count;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized self-checking bench for alu_share_arbiter against a transaction-level model
module tb_alu_share_arbiter;
  localparam int XLEN = 32;
  localparam int OPW = 4;
  localparam int CNTW = 4;
  logic clk_in = 0;
  logic rst_n_in;
  logic [1:0] req_valid_in, req_ready_out, rsp_valid_out, rsp_ready_in;
  logic [XLEN-1:0] req0_op_1_in, req0_op_2_in, req1_op_1_in, req1_op_2_in;
  logic [OPW-1:0] req0_opcode_in, req1_opcode_in, alu_opcode_out;
  logic [XLEN-1:0] rsp_result_out, alu_op_1_out, alu_op_2_out, alu_result_in;
  logic busy_out;
  logic [CNTW-1:0] done_count_out;
  int n_checks = 0;
  int n_fail = 0;
  logic m_last;
  logic [CNTW-1:0] m_count;
  alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req0_op_1_in(req0_op_1_in), .req0_op_2_in(req0_op_2_in), .req0_opcode_in(req0_opcode_in),
    .req1_op_1_in(req1_op_1_in), .req1_op_2_in(req1_op_2_in), .req1_opcode_in(req1_opcode_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in), .rsp_result_out(rsp_result_out),
    .alu_op_1_out(alu_op_1_out), .alu_op_2_out(alu_op_2_out), .alu_opcode_out(alu_opcode_out),
    .alu_result_in(alu_result_in), .busy_out(busy_out), .done_count_out(done_count_out)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [XLEN-1:0] alu_fn(input logic [OPW-1:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return '0;
    endcase
  endfunction
  assign alu_result_in = alu_fn(alu_opcode_out, alu_op_1_out, alu_op_2_out);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_outputs(input string tag);
    check({tag, "_ready"}, req_ready_out, 0);
    check({tag, "_rspv"}, rsp_valid_out, 0);
    check({tag, "_res"}, rsp_result_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_cnt"}, done_count_out, 0);
    check({tag, "_aop1"}, alu_op_1_out, 0);
    check({tag, "_aop2"}, alu_op_2_out, 0);
    check({tag, "_aopc"}, alu_opcode_out, 0);
  endtask
  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 0;
    req_valid_in = 0;
    rsp_ready_in = 0;
    #1 idle_outputs("reset");
    @(negedge clk_in);
    rst_n_in = 1;
    m_last = 1;
    m_count = 0;
  endtask
  task automatic txn(input logic [1:0] v, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0, input logic [OPW-1:0] c0,
                     input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1, input logic [OPW-1:0] c1,
                     input int hold, input bit wrong);
    logic w;
    logic [XLEN-1:0] ea, eb, exp;
    logic [OPW-1:0] ec;
    @(negedge clk_in);
    req_valid_in = v;
    req0_op_1_in = a0; req0_op_2_in = b0; req0_opcode_in = c0;
    req1_op_1_in = a1; req1_op_2_in = b1; req1_opcode_in = c1;
    rsp_ready_in = 0;
    #1;
    w = (v == 2'b11) ? ~m_last : v[1];
    ea = w ? a1 : a0; eb = w ? b1 : b0; ec = w ? c1 : c0;
    exp = alu_fn(ec, ea, eb);
    check("req_ready", req_ready_out, 2'b01 << w);
    @(negedge clk_in);
    req0_op_1_in = $urandom; req1_op_1_in = $urandom; req0_opcode_in = 4'($urandom); req1_opcode_in = 4'($urandom);
    #1;
    check("exec_busy", busy_out, 1);
    check("exec_ready", req_ready_out, 0);
    check("exec_rspv", rsp_valid_out, 0);
    @(negedge clk_in);
    check("rsp_valid", rsp_valid_out, 2'b01 << w);
    check("rsp_result", rsp_result_out, exp);
    check("alu_op1", alu_op_1_out, ea);
    check("alu_op2", alu_op_2_out, eb);
    check("alu_opc", alu_opcode_out, ec);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      check("hold_valid", rsp_valid_out, 2'b01 << w);
      check("hold_result", rsp_result_out, exp);
      check("hold_ready", req_ready_out, 0);
    end
    if (wrong) begin
      rsp_ready_in = 2'b01 << ~w;
      @(negedge clk_in);
      check("wrong_valid", rsp_valid_out, 2'b01 << w);
      check("wrong_cnt", done_count_out, m_count);
    end
    rsp_ready_in = 2'b01 << w;
    req_valid_in = 0;
    @(negedge clk_in);
    rsp_ready_in = 0;
    m_last = w;
    m_count++;
    check("done_cnt", done_count_out, m_count);
    check("done_busy", busy_out, 0);
    check("done_rspv", rsp_valid_out, 0);
    check("done_res", rsp_result_out, 0);
  endtask
  initial begin
    rst_n_in = 0;
    req_valid_in = 0;
    rsp_ready_in = 0;
    req0_op_1_in = 0; req0_op_2_in = 0; req0_opcode_in = 0;
    req1_op_1_in = 0; req1_op_2_in = 0; req1_opcode_in = 0;
    do_reset();
    txn(2'b01, 5, 7, 0, 0, 0, 0, 0, 0);
    check("single_cnt", done_count_out, 1);
    do_reset();
    txn(2'b11, 10, 3, 1, 32'hF0, 32'h0F, 4, 0, 0);
    txn(2'b11, 10, 3, 1, 32'hF0, 32'h0F, 4, 0, 0);
    txn(2'b11, 10, 3, 1, 32'hF0, 32'h0F, 4, 0, 0);
    txn(2'b11, 1, 2, 0, 32'hAA, 32'h55, 3, 5, 0);
    txn(2'b01, 9, 4, 2, 0, 0, 0, 1, 1);
    @(negedge clk_in);
    req_valid_in = 2'b01;
    req0_op_1_in = 32'h1234; req0_op_2_in = 1; req0_opcode_in = 0;
    @(negedge clk_in);
    check("mid_busy", busy_out, 1);
    rst_n_in = 0;
    #1 idle_outputs("midrst");
    @(negedge clk_in);
    idle_outputs("midrst_next");
    rst_n_in = 1;
    req_valid_in = 0;
    m_last = 1;
    m_count = 0;
    for (int i = 0; i < 40; i++)
      txn(2'($urandom_range(1, 3)), $urandom, $urandom, 4'($urandom), $urandom, $urandom, 4'($urandom),
          $urandom_range(0, 3), 1'($urandom));
    do_reset();
    for (int i = 0; i < 15; i++)
      txn(2'($urandom_range(1, 3)), $urandom, $urandom, 4'($urandom_range(0, 5)), $urandom, $urandom,
          4'($urandom_range(0, 5)), 0, 0);
    check("pre_wrap", done_count_out, 15);
    txn(2'b10, 1, 1, 0, 100, 1, 1, 0, 0);
    check("wrap", done_count_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
